// File: rtl/rr_bus_arbiter_pkg.sv
// Shared constants for the round-robin bus arbiter.
// Holds the FSM state encodings and the default maximum grant hold time.
package rr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int unsigned DEFAULT_MAX_HOLD = 32'd16;

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between pipeline masters and the round-robin arbiter.
interface rr_bus_arbiter_if #(
  parameter int LogNum = 3
);
  localparam int Num = 2 ** LogNum;

  logic [Num-1:0]    req;
  logic              done;
  logic [Num-1:0]    grant;
  logic [LogNum-1:0] grant_idx;
  logic              busy;
  logic              timeout;

  modport master (output req, output done,
                  input grant, input grant_idx, input busy, input timeout);
  modport slave  (input req, input done,
                  output grant, output grant_idx, output busy, output timeout);
endinterface

// File: rtl/rr_bus_arbiter_bitdemux.sv
// Bit demultiplexer: routes input bit i onto output line s, all other lines low.
module rr_bus_arbiter_bitdemux #(
  parameter int LogNum = 3
) (
  input  logic                   i,
  input  logic [LogNum-1:0]      s,
  output logic [2**LogNum-1:0]   o
);

  // Steer i onto the selected line.
  always_comb begin
    o    = {(2**LogNum){1'b0}};
    o[s] = i;
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for one shared resource; holds a grant until done,
// request drop, or MaxHold cycles, then inserts one turnaround cycle.
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int LogNum  = 3,
  parameter int MaxHold = DEFAULT_MAX_HOLD,
  parameter int HoldW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_bus_arbiter_if.slave  bus
);

  localparam int Num = 2 ** LogNum;
  localparam logic [LogNum-1:0] IdxOne = {{(LogNum-1){1'b0}}, 1'b1};
  localparam logic [HoldW-1:0]  CntOne = {{(HoldW-1){1'b0}}, 1'b1};
  localparam logic [HoldW-1:0]  CntMax = HoldW'(MaxHold - 1);

  arb_state_e        state_r, state_s;
  logic [LogNum-1:0] ptr_r, ptr_s;
  logic [LogNum-1:0] idx_r, idx_s;
  logic              busy_r, busy_s;
  logic              timeout_r, timeout_s;
  logic [HoldW-1:0]  cnt_r, cnt_s;
  logic [LogNum-1:0] winner_s;
  logic              found_s;
  logic              rel_user_s;
  logic              at_max_s;

  // Round-robin scan: first requester at or above ptr, wrapping modulo Num.
  always_comb begin
    logic [LogNum-1:0] cand;
    winner_s = ptr_r;
    found_s  = 1'b0;
    for (int i = 0; i < Num; i++) begin
      cand = ptr_r + LogNum'(i);
      if (!found_s && bus.req[cand]) begin
        winner_s = cand;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign rel_user_s = bus.done || !bus.req[idx_r];
  assign at_max_s   = (cnt_r == CntMax);

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    idx_s     = idx_r;
    busy_s    = busy_r;
    cnt_s     = cnt_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          idx_s   = winner_s;
          busy_s  = 1'b1;
          cnt_s   = {HoldW{1'b0}};
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (rel_user_s || at_max_s) begin
          busy_s    = 1'b0;
          ptr_s     = idx_r + IdxOne;
          state_s   = ST_RELEASE;
          // A forced release only counts as a timeout when nothing else ended it.
          timeout_s = at_max_s && !rel_user_s;
        end else begin
          cnt_s     = cnt_r + CntOne;
        end
      end
      ST_RELEASE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        cnt_s   = {HoldW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {LogNum{1'b0}};
      idx_r     <= {LogNum{1'b0}};
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= {HoldW{1'b0}};
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      idx_r     <= idx_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
      cnt_r     <= cnt_s;
    end
  end

  rr_bus_arbiter_bitdemux #(.LogNum(LogNum)) u_demux (
    .i (busy_r),
    .s (idx_r),
    .o (bus.grant)
  );

  assign bus.grant_idx = idx_r;
  assign bus.busy      = busy_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed self-checking bench for rr_bus_arbiter (LogNum=3, MaxHold=16).
module tb_rr_bus_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  rr_bus_arbiter_if #(.LogNum(3)) bus ();

  rr_bus_arbiter #(.LogNum(3), .MaxHold(16), .HoldW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic b, input logic t);
    chk({tag, ".grant"},     bus.grant,            g);
    chk({tag, ".grant_idx"}, {5'd0, bus.grant_idx}, {5'd0, idx});
    chk({tag, ".busy"},      {7'd0, bus.busy},      {7'd0, b});
    chk({tag, ".timeout"},   {7'd0, bus.timeout},   {7'd0, t});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] onehot;
    vectors  = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    tick();
    tick();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // No requests for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_all("idle", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Two requesters, ptr=0: idx 2 first, then idx 5.
    bus.req = 8'b0010_0100;
    tick();
    chk_all("pair.g2", 8'b0000_0100, 3'd2, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    chk_all("pair.rel2", 8'h00, 3'd2, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick();
    chk_all("pair.idle", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();
    chk_all("pair.g5", 8'b0010_0000, 3'd5, 1'b1, 1'b0);

    // Reset to ptr=0, then all requesters: order 0..7 then wrap to 0.
    rst_n = 1'b0;
    bus.req = 8'h00;
    tick();
    rst_n = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      onehot = 8'h01 << (k % 8);
      chk_all("all.grant", onehot, 3'(k % 8), 1'b1, 1'b0);
      bus.done = 1'b1;
      tick();
      chk_all("all.release", 8'h00, 3'(k % 8), 1'b0, 1'b0);
      bus.done = 1'b0;
      tick();
      chk_all("all.idle", 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end
    bus.req = 8'h00;
    tick();

    // Single req[3] held: 16-cycle grant, timeout pulse, re-grant 2 cycles later.
    bus.req = 8'b0000_1000;
    tick();
    chk_all("hold.start", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
    for (int c = 1; c < 16; c++) begin
      tick();
      chk_all("hold.run", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
    end
    tick();
    chk_all("hold.timeout", 8'h00, 3'd3, 1'b0, 1'b1);
    tick();
    chk_all("hold.after", 8'h00, 3'd3, 1'b0, 1'b0);
    tick();
    chk_all("hold.regrant", 8'b0000_1000, 3'd3, 1'b1, 1'b0);

    // Owner drops req with done=1 on the last hold cycle: normal release, ptr=4.
    bus.req = 8'b0011_1000;
    for (int c = 1; c < 16; c++) begin
      tick();
      chk_all("coinc.run", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
    end
    bus.req  = 8'b0011_0000;
    bus.done = 1'b1;
    tick();
    chk_all("coinc.release", 8'h00, 3'd3, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick();
    chk_all("coinc.idle", 8'h00, 3'd3, 1'b0, 1'b0);
    tick();
    chk_all("coinc.next", 8'b0001_0000, 3'd4, 1'b1, 1'b0);

    // Asynchronous reset between edges drops the grant immediately.
    #2 rst_n = 1'b0;
    #1;
    chk_all("areset", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.req = 8'b1000_0000;
    tick();
    chk_all("areset.hold", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("areset.g7", 8'b1000_0000, 3'd7, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    chk_all("areset.rel7", 8'h00, 3'd7, 1'b0, 1'b0);
    bus.done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
